// File: rtl/bin_down_cnt.sv
// Loadable, prescaled binary down-counter with a terminal-count pulse.
// The count register can either wrap at zero or stop there (one-shot).
module bin_down_cnt #(
  parameter int WIDTH = 4,
  parameter int DIV   = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             wrap,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc_pulse
);

  // With DIV == 1 the prescaler degenerates to a constant-zero bit, so the tick fires every enabled cycle.
  localparam int             PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(DIV - 1);

  logic [PW-1:0] prescaler;
  logic          tick;

  assign tick = en && (prescaler == PS_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      prescaler <= '0;
      tc_pulse  <= 1'b0;
    end else if (load) begin
      // A load discards any coincident tick and restarts the interval.
      count     <= load_val;
      prescaler <= '0;
      tc_pulse  <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      if (en) begin
        prescaler <= tick ? '0 : prescaler + PW'(1);
      end
      if (tick) begin
        if (count == WIDTH'(1)) begin
          count    <= '0;
          tc_pulse <= 1'b1;
        end else if (count == '0) begin
          // wrap is only consulted here; at any other time it is ignored.
          if (wrap) begin
            count <= '1;
          end
        end else begin
          count <= count - WIDTH'(1);
        end
      end
    end
  end

  assign zero = (count == '0);

endmodule

// File: doc/bin_down_cnt.md
# bin_down_cnt

Loadable, prescaled binary down-counter. It counts in the opposite direction to the lab's free-running up-counter and serves as the countdown/timer block for the board's LED and display datapath. A single system clock is divided internally into a tick enable; no derived clocks are generated. The block flags terminal count with a one-clock pulse and supports either wrap-around or one-shot (hold at zero) operation.

## Interface
- WIDTH, 4, counter width in bits (≥ 2)
- DIV, 10_000_000, clk cycles per count tick (≥ 1); the default gives 10 Hz from 100 MHz
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (low = reset)
- en  input  1  count enable; gates prescaler and counter
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value written to count on load
- wrap  input  1  1 = wrap 0 → 2^WIDTH−1; 0 = one-shot, hold at 0
- count  output  WIDTH  current count (registered)
- zero  output  1  high whenever count == 0
- tc_pulse  output  1  one-clk pulse when count decrements from 1 to 0

## Operation
- Prescaler: ceil(log2(DIV))-bit register, range 0..DIV−1. When en=1 it increments each clk. The internal tick is high in the cycle where prescaler == DIV−1, and the prescaler returns to 0 on that edge. When en=0 the prescaler holds its value. With DIV=1 the tick is high every enabled cycle.
- Priority per edge, highest first: reset, load, tick, hold.
- load=1: count ← load_val and prescaler ← 0, regardless of en or tick. tc_pulse is 0 in the following cycle.
- tick with count > 1: count ← count − 1.
- tick with count == 1: count ← 0 and tc_pulse ← 1 for exactly one clk.
- tick with count == 0 and wrap=1: count ← 2^WIDTH−1. No tc_pulse is generated.
- tick with count == 0 and wrap=0: count holds at 0. No pulse, and no repeated pulses.
- Loading 0 sets zero=1 and does not produce tc_pulse.
- zero is a pure decode of the count register, so it is glitch-free relative to count.
- Arithmetic is modulo 2^WIDTH. No other states exist: the operating mode is the (count, wrap) pair, and there is no separate FSM.
- wrap is sampled only at the tick where count == 0. Changing wrap at any other time has no effect.

## Timing
- Reset (rst low) forces the following immediately, without waiting for clk: count = 0, prescaler = 0, tc_pulse = 0, zero = 1.
- Release of rst is synchronous in effect. The first prescaler increment happens on the first rising edge with rst high and en=1.
- From load (prescaler = 0) with en held at 1, the first decrement lands on the DIV-th rising edge after the load edge. After that, decrements occur every DIV edges.
- Deasserting en freezes the partially elapsed interval. On re-enable, the remaining cycles complete the interval; the interval does not restart.
- tc_pulse is asserted in the same cycle that count first reads 0 and deasserts on the next edge.
- load and tick in the same cycle: the load wins, the tick is discarded, and the prescaler restarts at 0.
- Reset asserted mid-interval or during tc_pulse: all outputs return to their reset values at once, with no residual pulse after release.

## Test plan
All scenarios use WIDTH=4, DIV=4.
- Load and one-shot count: load_val=5, wrap=0, en=1 → count 5,4,3,2,1,0, each held 4 clks. tc_pulse is high for 1 clk exactly when count becomes 0. count then stays 0 for ≥ 20 clks with no further pulse, and zero=1.
- Wrap: load_val=1, wrap=1 → 1 → 0 (tc_pulse=1, zero=1) → 15 (no pulse, zero=0) → 14, with 4-clk spacing.
- Enable hold: load 9, en=1 for 2 clks, en=0 for 10 clks, en=1 → count stays 9 throughout the hold. It reaches 8 exactly 2 enabled clks after re-enable.
- Load/tick collision: count=7 with the prescaler at 3, pulse load=1 with load_val=12 → count=12 (not 6). The next decrement to 11 comes 4 clks later.
- Load zero: load_val=0, en=1, wrap=0 → zero=1, tc_pulse stays 0, count holds 0.
- Async reset: pull rst low mid-interval at count=3, and again during tc_pulse → count=0, zero=1, tc_pulse=0 before the next clk edge. After release, the count holds 0 until the next load (wrap=0).
